// File: rtl/rc4_encrypt_if.sv
// rc4_encrypt_if: signal bundle between the RC4 encryptor and its environment.
//   key        cipher key, byte 0 in [23:16]
//   start      begin an encryption run
//   pt_addr    plaintext ROM address (driven by the encryptor)
//   pt_rdata   plaintext ROM data, one cycle after pt_addr
//   debug_addr ciphertext RAM read address
//   debug_data ciphertext RAM read data, one cycle after debug_addr
//   busy/done  run status
// master = environment side (bench, ROM, reader); slave = encryptor side.
interface rc4_encrypt_if;
  logic [23:0] key;
  logic        start;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rdata;
  logic [7:0]  debug_addr;
  logic [7:0]  debug_data;
  logic        busy;
  logic        done;

  modport master (
    output key, start, pt_rdata, debug_addr,
    input  pt_addr, debug_data, busy, done
  );

  modport slave (
    input  key, start, pt_rdata, debug_addr,
    output pt_addr, debug_data, busy, done
  );
endinterface

// File: rtl/rc4_encrypt.sv
// rc4_encrypt: RC4 stream-cipher encryptor. On start, expands the 24-bit key
// into the S permutation (KSA), generates MSG_LEN keystream bytes (PRGA),
// XORs them with plaintext read from an external synchronous ROM and stores
// the ciphertext in an internal 256x8 RAM, readable through a debug port.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rc4_encrypt_if.slave (key, start, pt_addr/pt_rdata,
//          debug_addr/debug_data, busy, done)
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | waiting for start after reset
// INIT      | S[i] = i, one entry per cycle
// KSA_J     | j += S[i] + key byte (i mod 3)
// KSA_SWAP  | swap S[i], S[j]; advance i
// PRGA_J    | i += 1, j += S[i+1], issue plaintext address k
// PRGA_SWAP | swap S[i], S[j]; ROM data arrives this cycle
// PRGA_XOR  | ct[k] = S[S[i]+S[j]] ^ plaintext; advance k
// DONE      | ciphertext stable; start restarts from INIT
module rc4_encrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  rc4_encrypt_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    KSA_J     = 3'd2,
    KSA_SWAP  = 3'd3,
    PRGA_J    = 3'd4,
    PRGA_SWAP = 3'd5,
    PRGA_XOR  = 3'd6,
    DONE      = 3'd7
  } state_t;

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  state_t      current_state;
  logic [7:0]  i, j, k;
  logic [1:0]  key_sel;   // tracks i mod 3 during KSA without a divider
  logic [7:0]  pt_addr_q;
  logic [7:0]  debug_data_q;
  logic        busy_q, done_q;

  logic [7:0]  s_mem  [256];
  logic [7:0]  ct_mem [256];

  logic [7:0]  key_byte, s_i, s_j, i_nxt, s_i_nxt, ks_idx, ks_byte;

  always_comb begin
    case (key_sel)
      2'd0:    key_byte = bus.key[23:16];
      2'd1:    key_byte = bus.key[15:8];
      default: key_byte = bus.key[7:0];
    endcase
    i_nxt   = i + 8'd1;
    s_i     = s_mem[i];
    s_j     = s_mem[j];
    s_i_nxt = s_mem[i_nxt];
    ks_idx  = s_i + s_j;
    ks_byte = s_mem[ks_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      current_state <= IDLE;
      i             <= 8'd0;
      j             <= 8'd0;
      k             <= 8'd0;
      key_sel       <= 2'd0;
      pt_addr_q     <= 8'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (current_state)
        IDLE, DONE: begin
          if (bus.start) begin
            current_state <= INIT;
            i       <= 8'd0;
            j       <= 8'd0;
            k       <= 8'd0;
            key_sel <= 2'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        INIT: begin
          i <= i_nxt;   // wraps to 0 for KSA
          if (i == 8'hFF) current_state <= KSA_J;
        end
        KSA_J: begin
          j <= j + s_i + key_byte;
          current_state <= KSA_SWAP;
        end
        KSA_SWAP: begin
          i       <= i_nxt;
          key_sel <= (key_sel == 2'd2) ? 2'd0 : key_sel + 2'd1;
          if (i == 8'hFF) begin
            current_state <= PRGA_J;
            j <= 8'd0;
            k <= 8'd0;
          end else begin
            current_state <= KSA_J;
          end
        end
        PRGA_J: begin
          i         <= i_nxt;
          j         <= j + s_i_nxt;
          pt_addr_q <= k;
          current_state <= PRGA_SWAP;
        end
        PRGA_SWAP: current_state <= PRGA_XOR;
        PRGA_XOR: begin
          k <= k + 8'd1;
          if (k == LAST_K) begin
            current_state <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            current_state <= PRGA_J;
          end
        end
        default: current_state <= IDLE;
      endcase
    end
  end

  // S and ciphertext storage are not reset; during reset the FSM sits in
  // IDLE so neither is written. When i == j the swap writes the same value.
  always_ff @(posedge clk) begin
    case (current_state)
      INIT: s_mem[i] <= i;
      KSA_SWAP, PRGA_SWAP: begin
        s_mem[i] <= s_j;
        s_mem[j] <= s_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (current_state == PRGA_XOR) ct_mem[k] <= ks_byte ^ bus.pt_rdata;
  end

  // Read-before-write: a same-cycle write to debug_addr returns the old byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) debug_data_q <= 8'd0;
    else        debug_data_q <= ct_mem[bus.debug_addr];
  end

  assign bus.pt_addr    = pt_addr_q;
  assign bus.debug_data = debug_data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_rc4_encrypt.sv
module tb_rc4_encrypt;
  localparam int MSG_LEN  = 32;
  localparam int DONE_LAT = 768 + 3 * MSG_LEN;

  logic clk = 1'b0;
  logic rst_n;

  rc4_encrypt_if bus();

  rc4_encrypt #(.MSG_LEN(MSG_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External synchronous plaintext ROM
  logic [7:0] rom [256];
  always @(posedge clk) bus.pt_rdata <= rom[bus.pt_addr];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ks  [256];
  logic [7:0] rd  [256];
  logic [7:0] pre [256];
  logic [7:0] rd1 [256];
  logic [7:0] exp_q [$];

  // Reference RC4 with a 3-byte key, key[23:16] as byte 0
  task automatic compute_ks(input logic [23:0] kk, input int n);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] tmp;
    int ii, jj, t;
    kb[0] = kk[23:16];
    kb[1] = kk[15:8];
    kb[2] = kk[7:0];
    for (int x = 0; x < 256; x++) s[x] = x[7:0];
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(s[x]) + int'(kb[x % 3])) % 256;
      tmp = s[x]; s[x] = s[jj]; s[jj] = tmp;
    end
    ii = 0; jj = 0;
    for (int x = 0; x < n; x++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(s[ii])) % 256;
      tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
      t = (int'(s[ii]) + int'(s[jj])) % 256;
      ks[x] = s[t];
    end
  endtask

  task automatic push_expected(input logic [23:0] kk);
    compute_ks(kk, MSG_LEN);
    for (int x = 0; x < MSG_LEN; x++) exp_q.push_back(rom[x] ^ ks[x]);
  endtask

  task automatic read_ct(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      @(negedge clk);
      bus.debug_addr = a[7:0];
      @(posedge clk);
      #1;
      rd[a] = bus.debug_data;
    end
  endtask

  // Pulse start, then count edges until done; optionally pokes start again
  // at edge poke_at. cycles = -1 on timeout.
  task automatic run_to_done(input int poke_at, output int cycles, output bit busy_ok);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy_ok = (bus.busy === 1'b1) && (bus.done === 1'b0);
    cycles = -1;
    for (int n = 1; n <= DONE_LAT + 200; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        cycles = n;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (n == poke_at - 1) bus.start = 1'b1;
      if (n == poke_at)     bus.start = 1'b0;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.key = 24'h0;
    bus.debug_addr = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (dut.current_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", dut.current_state); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_checks++; if (bus.pt_addr !== 8'h0) begin n_fail++; $display("FAIL reset_pt_addr got %h want 00", bus.pt_addr); end
    n_checks++; if (bus.debug_data !== 8'h0) begin n_fail++; $display("FAIL reset_debug_data got %h want 00", bus.debug_data); end
    @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_golden_latency;
    string msg;
    int cyc;
    bit bok;
    logic [7:0] e;
    msg = "The quick brown fox jumps over 1";
    bus.key = 24'h1E4600;
    for (int x = 0; x < 256; x++) rom[x] = (x < msg.len()) ? msg[x] : 8'h00;
    read_ct(MSG_LEN, 255);
    for (int a = MSG_LEN; a < 256; a++) pre[a] = rd[a];
    push_expected(24'h1E4600);
    run_to_done(400, cyc, bok);
    n_checks++; if (cyc != DONE_LAT) begin n_fail++; $display("FAIL golden_latency got %0d want %0d", cyc, DONE_LAT); end
    n_checks++; if (!bok) begin n_fail++; $display("FAIL golden_busy_window got low want high"); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL golden_busy_at_done got %b want 0", bus.busy); end
    read_ct(0, MSG_LEN - 1);
    for (int a = 0; a < MSG_LEN; a++) begin
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL golden_ct[%0d] scoreboard empty", a); end
      else begin
        e = exp_q.pop_front();
        if (rd[a] !== e) begin n_fail++; $display("FAIL golden_ct[%0d] got %h want %h", a, rd[a], e); end
      end
    end
    read_ct(MSG_LEN, 255);
    for (int a = MSG_LEN; a < 256; a++) begin
      n_checks++;
      if (rd[a] !== pre[a]) begin n_fail++; $display("FAIL golden_untouched[%0d] got %h want %h", a, rd[a], pre[a]); end
    end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL golden_done_level got %b want 1", bus.done); end
  endtask

  task automatic test_round_trip;
    int cyc;
    bit bok;
    logic [7:0] e;
    bus.key = 24'h1E4600;
    for (int x = 0; x < 256; x++) rom[x] = 8'h00;
    push_expected(24'h1E4600);
    run_to_done(-10, cyc, bok);
    n_checks++; if (cyc != DONE_LAT) begin n_fail++; $display("FAIL rt_pass1_latency got %0d want %0d", cyc, DONE_LAT); end
    read_ct(0, MSG_LEN - 1);
    for (int a = 0; a < MSG_LEN; a++) begin
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL rt_keystream[%0d] scoreboard empty", a); end
      else begin
        e = exp_q.pop_front();
        if (rd[a] !== e) begin n_fail++; $display("FAIL rt_keystream[%0d] got %h want %h", a, rd[a], e); end
      end
    end
    for (int x = 0; x < MSG_LEN; x++) begin
      rom[x] = rd[x];
      exp_q.push_back(8'h00);
    end
    run_to_done(-10, cyc, bok);
    n_checks++; if (cyc != DONE_LAT) begin n_fail++; $display("FAIL rt_pass2_latency got %0d want %0d", cyc, DONE_LAT); end
    n_checks++; if (!bok) begin n_fail++; $display("FAIL rt_pass2_busy_window got low want high"); end
    read_ct(0, MSG_LEN - 1);
    for (int a = 0; a < MSG_LEN; a++) begin
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL rt_zero[%0d] scoreboard empty", a); end
      else begin
        e = exp_q.pop_front();
        if (rd[a] !== e) begin n_fail++; $display("FAIL rt_zero[%0d] got %h want %h", a, rd[a], e); end
      end
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    bit bok;
    logic [7:0] e;
    bus.key = 24'h0A0B0C;
    for (int x = 0; x < 256; x++) rom[x] = 8'(x * 7 + 3);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (499) @(posedge clk);
    #1;
    n_checks++;
    if (dut.current_state !== 3'd2 && dut.current_state !== 3'd3) begin
      n_fail++; $display("FAIL midrun_in_ksa got state %0d want 2 or 3", dut.current_state);
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (dut.current_state !== 3'd0) begin n_fail++; $display("FAIL midrun_state got %0d want 0", dut.current_state); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrun_busy got %b want 0", bus.busy); end
    n_checks++;
    if (dut.i !== 8'h0 || dut.j !== 8'h0 || dut.k !== 8'h0) begin
      n_fail++; $display("FAIL midrun_ijk got %h/%h/%h want 00/00/00", dut.i, dut.j, dut.k);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_expected(24'h0A0B0C);
    run_to_done(-10, cyc, bok);
    n_checks++; if (cyc != DONE_LAT) begin n_fail++; $display("FAIL midrun_latency got %0d want %0d", cyc, DONE_LAT); end
    read_ct(0, MSG_LEN - 1);
    for (int a = 0; a < MSG_LEN; a++) begin
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL midrun_ct[%0d] scoreboard empty", a); end
      else begin
        e = exp_q.pop_front();
        if (rd[a] !== e) begin n_fail++; $display("FAIL midrun_ct[%0d] got %h want %h", a, rd[a], e); end
      end
    end
  endtask

  task automatic test_key_order;
    int cyc;
    bit bok;
    int ndiff;
    logic [7:0] e;
    for (int x = 0; x < 256; x++) rom[x] = 8'(8'hA5 ^ x);
    bus.key = 24'h000001;
    push_expected(24'h000001);
    run_to_done(-10, cyc, bok);
    n_checks++; if (cyc != DONE_LAT) begin n_fail++; $display("FAIL keyA_latency got %0d want %0d", cyc, DONE_LAT); end
    read_ct(0, MSG_LEN - 1);
    for (int a = 0; a < MSG_LEN; a++) begin
      rd1[a] = rd[a];
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL keyA_ct[%0d] scoreboard empty", a); end
      else begin
        e = exp_q.pop_front();
        if (rd[a] !== e) begin n_fail++; $display("FAIL keyA_ct[%0d] got %h want %h", a, rd[a], e); end
      end
    end
    bus.key = 24'h010000;
    push_expected(24'h010000);
    run_to_done(-10, cyc, bok);
    n_checks++; if (cyc != DONE_LAT) begin n_fail++; $display("FAIL keyB_latency got %0d want %0d", cyc, DONE_LAT); end
    read_ct(0, MSG_LEN - 1);
    ndiff = 0;
    for (int a = 0; a < MSG_LEN; a++) begin
      if (rd[a] !== rd1[a]) ndiff++;
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL keyB_ct[%0d] scoreboard empty", a); end
      else begin
        e = exp_q.pop_front();
        if (rd[a] !== e) begin n_fail++; $display("FAIL keyB_ct[%0d] got %h want %h", a, rd[a], e); end
      end
    end
    n_checks++; if (ndiff == 0) begin n_fail++; $display("FAIL key_order_differ got 0 differing bytes want >0"); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.key = 24'h0;
    bus.debug_addr = 8'h0;
    for (int x = 0; x < 256; x++) rom[x] = 8'h00;
    test_reset();
    test_golden_latency();
    test_round_trip();
    test_reset_mid_run();
    test_key_order();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
